// File: rtl/mem_io_responder.sv
// Byte-wide CPU bus target: 128KB RAM plus MMIO (UART TX FIFO / RX, cycle counter, stop flag).
// Reads return 1 cycle after the address and writes commit at the edge; io_buffer_full throttles TX writes with 2 slots spare.
module mem_io_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH      = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    output logic [7:0]  bus_dout,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(TX_DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(TX_DEPTH - 2);

    logic [7:0]    r_ram   [2**RAM_ADDR_BITS];
    logic [7:0]    r_txmem [TX_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_cyc;
    logic [31:0]   r_snap;
    logic [7:0]    r_dout;
    logic          r_afull;
    logic          r_stop;
    logic          r_ovf;

    logic                     w_io;
    logic                     w_rd;
    logic                     w_wr;
    logic                     w_off0;
    logic                     w_off4;
    logic [RAM_ADDR_BITS-1:0] w_ram_addr;
    logic [7:0]               w_ram_rdata;
    logic [7:0]               w_io_rdata;
    logic                     w_push_req;
    logic                     w_push;
    logic                     w_pop;
    logic [7:0]               w_push_dat;
    logic [CW-1:0]            w_cnt_nxt;
    logic                     w_unused_hi;

    assign w_io        = (bus_a[17:16] == 2'b11);
    assign w_rd        = rdy_in & ~bus_wr;
    assign w_wr        = rdy_in & bus_wr;
    assign w_off0      = (bus_a[15:0] == 16'h0000);
    assign w_off4      = (bus_a[15:0] == 16'h0004);
    assign w_ram_addr  = bus_a[RAM_ADDR_BITS-1:0];
    assign w_ram_rdata = r_ram[w_ram_addr];
    assign w_unused_hi = &{1'b0, bus_a[31:18]};

    // Offset 4 always pushes a zero byte so the UART side sees the stop marker.
    assign w_push_req = w_wr & w_io & ((w_off0 & (bus_din != 8'h00)) | w_off4);
    assign w_push_dat = w_off4 ? 8'h00 : bus_din;
    assign tx_valid   = (r_cnt != '0);
    assign tx_data    = tx_valid ? r_txmem[r_rd_ptr] : 8'h00;
    assign w_pop      = tx_valid & tx_ready;
    assign w_push     = w_push_req & ((r_cnt != FULL_CNT) | w_pop);

    assign rx_pop         = rst_in & w_rd & w_io & w_off0 & rx_valid;
    assign bus_dout       = r_dout;
    assign io_buffer_full = r_afull;
    assign program_stop   = r_stop;
    assign tx_overflow    = r_ovf;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_comb begin
        w_io_rdata = 8'h00;
        case (bus_a[15:0])
            16'h0000: if (rx_valid) w_io_rdata = rx_data;
            16'h0004: w_io_rdata = r_cyc[7:0];
            16'h0005: w_io_rdata = r_snap[15:8];
            16'h0006: w_io_rdata = r_snap[23:16];
            16'h0007: w_io_rdata = r_snap[31:24];
            default:  w_io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dout   <= 8'h00;
            r_cyc    <= 32'd0;
            r_snap   <= 32'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_afull  <= 1'b0;
            r_stop   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (rdy_in) begin
                r_cyc <= r_cyc + 32'd1;
            end
            if (w_rd) begin
                r_dout <= w_io ? w_io_rdata : w_ram_rdata;
                if (w_io && w_off4) begin
                    r_snap <= r_cyc;
                end
            end
            if (w_wr && w_io && w_off4) begin
                r_stop <= 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_afull <= (w_cnt_nxt >= AFULL_CNT);
        end
    end

    // Storage arrays carry no reset; only pointers and count are cleared.
    always_ff @(posedge clk_in) begin
        if (w_wr && !w_io) begin
            r_ram[w_ram_addr] <= bus_din;
        end
        if (w_push) begin
            r_txmem[r_wr_ptr] <= w_push_dat;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: RAM, pipelined reads, cycle counter, UART RX/TX, stop and reset.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] bus_a;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic [7:0]  bus_dout;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        program_stop;
    logic        tx_overflow;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] m_cyc;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .bus_a(bus_a), .bus_din(bus_din), .bus_wr(bus_wr), .bus_dout(bus_dout),
        .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: counts enabled cycles since reset.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) m_cyc <= 32'd0;
        else if (rdy_in) m_cyc <= m_cyc + 32'd1;
    end

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus_wr = wr; bus_a = a; bus_din = d;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0000_0000, 8'h00);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle();
        #2 rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("FAIL reset_bus_dout got=%h exp=00", bus_dout); end
        total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_io_full got=%b exp=0", io_buffer_full); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL reset_rx_pop got=%b exp=0", rx_pop); end
        total++; if (program_stop !== 1'b0) begin bad++; $display("FAIL reset_stop got=%b exp=0", program_stop); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", tx_overflow); end
        rst_in = 1'b1; rdy_in = 1'b1;
    endtask

    task automatic test_ram_rw();
        logic        wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_t  [4] = '{32'h20, 32'h20, 32'h10, 32'h10};
        logic [7:0]  d_t  [4] = '{8'h5C, 8'h00, 8'hA5, 8'h00};
        logic [7:0]  e_t  [4] = '{8'h00, 8'h5C, 8'h5C, 8'hA5};
        logic [7:0]  exp;
        for (int i = 0; i < 4; i++) begin
            drive(wr_t[i], a_t[i], d_t[i]);
            if (i > 0) rd_q.push_back(e_t[i]);
            @(negedge clk_in);
            if (rd_q.size() > 0) begin
                exp = rd_q.pop_front();
                total++;
                if (bus_dout !== exp) begin bad++; $display("FAIL ram_rw step=%0d got=%h exp=%h", i, bus_dout, exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        wr_t [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] a_t  [7] = '{32'h0, 32'h1, 32'h2, 32'h0, 32'h1, 32'h2, 32'h30008};
        logic [7:0]  d_t  [7] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0]  e_t  [7] = '{8'hA5, 8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h00};
        logic [7:0]  exp;
        for (int i = 0; i < 7; i++) begin
            drive(wr_t[i], a_t[i], d_t[i]);
            rd_q.push_back(e_t[i]);
            @(negedge clk_in);
            exp = rd_q.pop_front();
            total++;
            if (bus_dout !== exp) begin bad++; $display("FAIL b2b step=%0d got=%h exp=%h", i, bus_dout, exp); end
        end
    endtask

    task automatic test_cycle_counter();
        logic [31:0] snap;
        logic [31:0] got;
        logic [7:0]  exp;
        repeat (300) begin idle(); @(negedge clk_in); end
        snap = m_cyc;
        got = 32'd0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 32'h30004 + j, 8'h00);
            rd_q.push_back(snap[8*j +: 8]);
            @(negedge clk_in);
            exp = rd_q.pop_front();
            got[8*j +: 8] = bus_dout;
            total++;
            if (bus_dout !== exp) begin bad++; $display("FAIL cyc_byte%0d got=%h exp=%h", j, bus_dout, exp); end
        end
        total++;
        if (got !== snap) begin bad++; $display("FAIL cyc_reassemble got=%h exp=%h", got, snap); end
        rdy_in = 1'b0;
        drive(1'b0, 32'h30004, 8'h00);
        repeat (10) @(negedge clk_in);
        total++;
        if (bus_dout !== snap[31:24]) begin bad++; $display("FAIL cyc_hold_dout got=%h exp=%h", bus_dout, snap[31:24]); end
        rdy_in = 1'b1;
        got = snap + 32'd4;
        rd_q.push_back(got[7:0]);
        @(negedge clk_in);
        exp = rd_q.pop_front();
        total++;
        if (bus_dout !== exp) begin bad++; $display("FAIL cyc_after_hold got=%h exp=%h", bus_dout, exp); end
    endtask

    task automatic test_rx();
        logic [7:0] exp;
        rx_valid = 1'b1; rx_data = 8'h37;
        drive(1'b0, 32'h30000, 8'h00);
        rd_q.push_back(8'h37);
        #1;
        total++; if (rx_pop !== 1'b1) begin bad++; $display("FAIL rx_pop_pulse got=%b exp=1", rx_pop); end
        @(negedge clk_in);
        exp = rd_q.pop_front();
        total++; if (bus_dout !== exp) begin bad++; $display("FAIL rx_data got=%h exp=%h", bus_dout, exp); end
        idle();
        #1;
        total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_single got=%b exp=0", rx_pop); end
        rdy_in = 1'b0;
        drive(1'b0, 32'h30000, 8'h00);
        #1;
        total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_rdy_low got=%b exp=0", rx_pop); end
        rdy_in = 1'b1; rx_valid = 1'b0;
        rd_q.push_back(8'h00);
        @(negedge clk_in);
        exp = rd_q.pop_front();
        total++; if (bus_dout !== exp) begin bad++; $display("FAIL rx_empty got=%h exp=%h", bus_dout, exp); end
    endtask

    task automatic test_tx_fifo();
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h30000, 8'h41 + 8'(i));
            tx_q.push_back(8'h41 + 8'(i));
            @(negedge clk_in);
            total++;
            if (io_buffer_full !== (i >= 5)) begin bad++; $display("FAIL tx_afull push=%0d got=%b exp=%b", i + 1, io_buffer_full, (i >= 5)); end
        end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL tx_ovf_at_full got=%b exp=0", tx_overflow); end
        exp = tx_q.pop_front();
        total++; if (tx_data !== exp) begin bad++; $display("FAIL tx_head_full got=%h exp=%h", tx_data, exp); end
        tx_ready = 1'b1;
        drive(1'b1, 32'h30000, 8'h49);
        tx_q.push_back(8'h49);
        @(negedge clk_in);
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL tx_ovf_push_pop got=%b exp=0", tx_overflow); end
        total++; if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL tx_afull_push_pop got=%b exp=1", io_buffer_full); end
        tx_ready = 1'b0;
        drive(1'b1, 32'h30000, 8'h4A);
        @(negedge clk_in);
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL tx_ovf_drop got=%b exp=1", tx_overflow); end
        idle();
        rdy_in = 1'b0; tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = tx_q.pop_front();
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin bad++; $display("FAIL tx_drain k=%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, exp); end
            @(negedge clk_in);
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
        total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL tx_afull_clear got=%b exp=0", io_buffer_full); end
        rdy_in = 1'b1; tx_ready = 1'b0;
    endtask

    task automatic test_zero_stop();
        logic [7:0] exp;
        total++; if (program_stop !== 1'b0) begin bad++; $display("FAIL stop_before got=%b exp=0", program_stop); end
        drive(1'b1, 32'h30000, 8'h00);
        @(negedge clk_in);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL zero_filter got=%b exp=0", tx_valid); end
        drive(1'b1, 32'h30004, 8'h00);
        tx_q.push_back(8'h00);
        @(negedge clk_in);
        drive(1'b1, 32'h30004, 8'h5A);
        tx_q.push_back(8'h00);
        @(negedge clk_in);
        idle();
        total++; if (program_stop !== 1'b1) begin bad++; $display("FAIL stop_set got=%b exp=1", program_stop); end
        tx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp = tx_q.pop_front();
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin bad++; $display("FAIL stop_byte k=%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, exp); end
            @(negedge clk_in);
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL stop_drained got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30000, 8'h61 + 8'(i));
            @(negedge clk_in);
        end
        drive(1'b0, 32'h10, 8'h00);
        rd_q.push_back(8'hA5);
        @(negedge clk_in);
        exp = rd_q.pop_front();
        total++; if (bus_dout !== exp) begin bad++; $display("FAIL mid_pre_read got=%h exp=%h", bus_dout, exp); end
        rx_valid = 1'b1; rx_data = 8'h37;
        drive(1'b0, 32'h30000, 8'h00);
        #2 rst_in = 1'b0;
        #1;
        total++;
        if ({bus_dout, io_buffer_full, tx_valid, tx_data, rx_pop, program_stop, tx_overflow} !== 21'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got dout=%h full=%b txv=%b txd=%h pop=%b stop=%b ovf=%b exp all zero",
                     bus_dout, io_buffer_full, tx_valid, tx_data, rx_pop, program_stop, tx_overflow);
        end
        tx_q.delete(); rd_q.delete();
        @(negedge clk_in);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("FAIL mid_inflight got=%h exp=00", bus_dout); end
        rst_in = 1'b1; rx_valid = 1'b0;
        drive(1'b0, 32'h10, 8'h00);
        rd_q.push_back(8'hA5);
        @(negedge clk_in);
        exp = rd_q.pop_front();
        total++; if (bus_dout !== exp) begin bad++; $display("FAIL mid_ram_kept got=%h exp=%h", bus_dout, exp); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_fifo_discard got=%b exp=0", tx_valid); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram_rw();
        test_back_to_back();
        test_cycle_counter();
        test_rx();
        test_tx_fifo();
        test_zero_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
